daisy_chain_spi_sequencer: RTL
==============================

# daisy_chain_spi_sequencer

On-chip SPI master and frame scheduler for the daisy-chained VT sensor array. It holds one configuration word per sensor and shifts a full N-sensor frame through the chain: MOSI enters sensor 0 and MISO leaves sensor N-1. Each frame also captures the words shifted back out of the chain. It sits between the SPI mux and the chained sensors, in place of an external host, and supports single-shot or periodic frames.

## Interface
- N_SENSORS, 4: number of chained sensors.
- FRAME_BITS, 16: shift-register width per sensor.
- CLK_DIV, 4: SPI half-period in CLK cycles (≥1).
- AW, 2: address width, clog2(N_SENSORS).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CFG_WE  in  1  write CFG_DATA into config slot CFG_ADDR.
- CFG_ADDR  in  AW  config slot index.
- CFG_DATA  in  FRAME_BITS  config word.
- START  in  1  single-cycle frame request.
- AUTO_EN  in  1  enable periodic frames.
- AUTO_PERIOD  in  16  idle cycles between DONE and the next auto frame.
- RD_ADDR  in  AW  capture slot select.
- RD_DATA  out  FRAME_BITS  capture slot contents (combinational read).
- BUSY  out  1  frame in progress.
- DONE  out  1  one-cycle pulse at frame end.
- SPI_CS  out  1  chip select, active-low.
- SPI_CLK  out  1  serial clock, mode 0.
- SPI_MOSI  out  1  serial data to sensor 0.
- SPI_MISO  in  1  serial data from sensor N-1.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, HOLD.
- IDLE
  - On START, or on an auto trigger, latch the N×FRAME_BITS shift register from the config buffer.
  - Load order: slot N-1 goes out first, MSB first, down to slot 0 LSB last.
  - Drive SPI_CS=0, set BUSY=1, present the first bit on MOSI, then go to SHIFT_LO.
- SHIFT_LO: SPI_CLK=0 for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI
  - SPI_CLK=1 for CLK_DIV cycles.
  - Sample SPI_MISO on the edge that raises SPI_CLK.
  - After CLK_DIV cycles, if bits remain: shift, drive the next MOSI bit with SPI_CLK falling, and go to SHIFT_LO.
  - Otherwise set SPI_CLK=0 and go to HOLD.
- HOLD
  - Keep SPI_CS low for CLK_DIV cycles.
  - Then set SPI_CS=1, BUSY=0, and pulse DONE.
  - Copy the captured bits into the capture buffer atomically; the first FRAME_BITS received go to slot N-1, the last FRAME_BITS to slot 0. Return to IDLE.
- Config writes are accepted at any time. An in-flight frame uses its snapshot, so writes take effect next frame. CFG_ADDR ≥ N_SENSORS is ignored.
- RD_DATA shows the previous completed frame until the DONE cycle updates it.
- START while BUSY is ignored, with no queueing.
- Auto mode
  - The idle counter clears on DONE and increments in IDLE while AUTO_EN=1.
  - The frame starts when count = AUTO_PERIOD. AUTO_PERIOD=0 behaves as 1.
  - START and an auto trigger in the same cycle produce exactly one frame, and START restarts the counter from DONE.
  - AUTO_EN=0 clears the counter.
- Shift and bit counters have widths sized for N_SENSORS×FRAME_BITS. There is no wrap inside a frame.

## Timing
- Reset values: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, BUSY=0, DONE=0. Config and capture buffers clear to 0, so RD_DATA=0. Counters clear to 0.
- RST mid-frame forces the reset values immediately (asynchronously). The partial frame is discarded and the capture buffer is cleared.
- All SPI outputs are registered.
- START sampled at edge t gives SPI_CS=0 and BUSY=1 after edge t.
- Per bit: 2×CLK_DIV cycles. MOSI is stable for the whole SPI_CLK high phase.
- SPI_CS low to DONE: 2×CLK_DIV×N_SENSORS×FRAME_BITS + CLK_DIV cycles. With defaults this is 516. DONE and the SPI_CS rise occur on the same edge.
- The earliest next manual START is accepted the cycle after DONE.
- With AUTO_PERIOD=P, SPI_CS falls P+1 cycles after the DONE edge.

## Test plan
- Reset
  - Stimulus: assert RST mid-SHIFT_HI at bit 30.
  - Required: SPI_CS=1, SPI_CLK=0, BUSY=0 immediately; no DONE; RD_DATA=0 for all slots.
- Single frame
  - Stimulus: config slots 0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444; START; MISO driven from a 64-bit chain model preloaded with 16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3.
  - Required: MOSI stream starts 4444… and ends …1111; DONE 516 cycles after SPI_CS falls; RD_DATA slots 0..3 = A0A0, B1B1, C2C2, D3D3; model holds the config words.
- Busy protection
  - Stimulus: START at cycle 10 of a frame, plus a CFG_WE to slot 2 with 16'hFFFF.
  - Required: no restart; frame length unchanged; current frame still shifts 3333; next frame shifts FFFF.
- Auto mode
  - Stimulus: AUTO_EN=1, AUTO_PERIOD=20.
  - Required: SPI_CS falls 21 cycles after each DONE; three consecutive frames occur.
  - Stimulus: AUTO_PERIOD=0.
  - Required: gap of 1 cycle.
- Collision
  - Stimulus: START coincident with the auto trigger.
  - Required: one frame, one DONE.
- Timing
  - Stimulus: CLK_DIV=1.
  - Required: SPI_CLK toggles every cycle; DONE 129 cycles after SPI_CS falls.

Source files
------------

// File: rtl/daisy_chain_spi_sequencer_if.sv
// ============================================================================
// daisy_chain_spi_sequencer_if : config, capture, control and SPI pin bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface daisy_chain_spi_sequencer_if #(
   parameter int FRAME_BITS = 16,
   parameter int AW         = 2
);
   logic                  i_cfg_we;
   logic [AW-1:0]         i_cfg_addr;
   logic [FRAME_BITS-1:0] i_cfg_data;
   logic                  i_start;
   logic                  i_auto_en;
   logic [15:0]           i_auto_period;
   logic [AW-1:0]         i_rd_addr;
   logic [FRAME_BITS-1:0] o_rd_data;
   logic                  o_busy;
   logic                  o_done;
   logic                  o_spi_cs;
   logic                  o_spi_clk;
   logic                  o_spi_mosi;
   logic                  i_spi_miso;

   modport slave (
      input  i_cfg_we, i_cfg_addr, i_cfg_data, i_start, i_auto_en,
             i_auto_period, i_rd_addr, i_spi_miso,
      output o_rd_data, o_busy, o_done, o_spi_cs, o_spi_clk, o_spi_mosi
   );

   modport master (
      output i_cfg_we, i_cfg_addr, i_cfg_data, i_start, i_auto_en,
             i_auto_period, i_rd_addr, i_spi_miso,
      input  o_rd_data, o_busy, o_done, o_spi_cs, o_spi_clk, o_spi_mosi
   );
endinterface

`default_nettype wire

// File: rtl/daisy_chain_spi_sequencer.sv
// ============================================================================
// daisy_chain_spi_sequencer : SPI mode-0 master shifting one full frame
// through a chain of N sensors, with single-shot and periodic scheduling.
// Rev 1.0
// ============================================================================
`default_nettype none

module daisy_chain_spi_sequencer #(
   parameter int N_SENSORS  = 4,
   parameter int FRAME_BITS = 16,
   parameter int CLK_DIV    = 4,
   parameter int AW         = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   daisy_chain_spi_sequencer_if.slave    bus
);

   localparam int TOTAL = N_SENSORS * FRAME_BITS;
   localparam int BCW   = $clog2(TOTAL + 1);
   localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]  c_DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BCW-1:0] c_BIT_LAST = BCW'(TOTAL - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_SHIFT_LO = 2'd1,
      S_SHIFT_HI = 2'd2,
      S_HOLD     = 2'd3
   } state_t;

   state_t                r_state;
   logic [FRAME_BITS-1:0] r_cfg     [N_SENSORS];
   logic [FRAME_BITS-1:0] r_cap_buf [N_SENSORS];
   logic [TOTAL-1:0]      r_shift;
   logic [TOTAL-1:0]      r_cap;
   logic [BCW-1:0]        r_bit;
   logic [DW-1:0]         r_div;
   logic [15:0]           r_idle;
   logic                  r_cs;
   logic                  r_sclk;
   logic                  r_mosi;
   logic                  r_busy;
   logic                  r_done;

   logic [AW-1:0]         w_cfg_addr;
   logic [AW-1:0]         w_rd_addr;
   logic [TOTAL-1:0]      w_snapshot;
   logic [15:0]           w_period;
   logic                  w_div_end;
   logic                  w_auto_trig;
   logic                  w_go;
   logic                  w_cfg_ok;

   assign w_cfg_addr  = bus.i_cfg_addr;
   assign w_rd_addr   = bus.i_rd_addr;
   assign w_cfg_ok    = bus.i_cfg_we && (int'(w_cfg_addr) < N_SENSORS);
   assign w_div_end   = (r_div == c_DIV_LAST);
   assign w_period    = (bus.i_auto_period == 16'd0) ? 16'd1 : bus.i_auto_period;
   assign w_auto_trig = bus.i_auto_en && (r_idle >= w_period);
   assign w_go        = bus.i_start || w_auto_trig;

   // Slot N-1 occupies the top of the frame so it leaves the master first.
   always_comb begin
      w_snapshot = '0;
      for (int i = 0; i < N_SENSORS; i++) begin
         w_snapshot[i*FRAME_BITS +: FRAME_BITS] = r_cfg[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cap   <= '0;
         r_bit   <= '0;
         r_div   <= '0;
         r_idle  <= '0;
         r_cs    <= 1'b1;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int i = 0; i < N_SENSORS; i++) begin
            r_cfg[i]     <= '0;
            r_cap_buf[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         if (w_cfg_ok) begin
            r_cfg[w_cfg_addr] <= bus.i_cfg_data;
         end
         case (r_state)
            S_IDLE: begin
               r_div <= '0;
               r_bit <= '0;
               if (w_go) begin
                  r_shift <= w_snapshot;
                  r_mosi  <= w_snapshot[TOTAL-1];
                  r_cs    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_idle  <= '0;
                  r_state <= S_SHIFT_LO;
               end else if (!bus.i_auto_en) begin
                  r_idle <= '0;
               end else begin
                  r_idle <= r_idle + 16'd1;
               end
            end
            S_SHIFT_LO: begin
               if (w_div_end) begin
                  r_div   <= '0;
                  r_sclk  <= 1'b1;
                  r_cap   <= {r_cap[TOTAL-2:0], bus.i_spi_miso};
                  r_state <= S_SHIFT_HI;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_SHIFT_HI: begin
               if (w_div_end) begin
                  r_div  <= '0;
                  r_sclk <= 1'b0;
                  if (r_bit != c_BIT_LAST) begin
                     r_shift <= r_shift << 1;
                     r_mosi  <= r_shift[TOTAL-2];
                     r_bit   <= r_bit + 1'b1;
                     r_state <= S_SHIFT_LO;
                  end else begin
                     r_state <= S_HOLD;
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_HOLD: begin
               if (w_div_end) begin
                  r_div   <= '0;
                  r_cs    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_idle  <= '0;
                  r_state <= S_IDLE;
                  // Last word received belongs to sensor 0, so it lands in slot 0.
                  for (int i = 0; i < N_SENSORS; i++) begin
                     r_cap_buf[i] <= r_cap[i*FRAME_BITS +: FRAME_BITS];
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_rd_data  = r_cap_buf[w_rd_addr];
   assign bus.o_busy     = r_busy;
   assign bus.o_done     = r_done;
   assign bus.o_spi_cs   = r_cs;
   assign bus.o_spi_clk  = r_sclk;
   assign bus.o_spi_mosi = r_mosi;

endmodule

`default_nettype wire
